// File: rtl/exc_issuer_if.sv
// rtl/exc_issuer_if.sv - decode/CP0 side bundle for exc_issuer (ext_int present only with EXC_INT_EN)
interface exc_issuer_if;
  logic        stall;
  logic        id_valid;
  logic        id_syscall;
  logic        id_break;
  logic        id_teq;
  logic        id_eret;
  logic        teq_eq;
  logic [31:0] id_pc;
  logic [31:0] status;
  logic [31:0] epc_in;
`ifdef EXC_INT_EN
  logic        ext_int;
`endif
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;

`ifdef EXC_INT_EN
  modport master (
    output stall, id_valid, id_syscall, id_break, id_teq, id_eret, teq_eq,
           id_pc, status, epc_in, ext_int,
    input  exception, eret, cause, exc_pc, redirect, redirect_pc, flush, busy
  );
  modport slave (
    input  stall, id_valid, id_syscall, id_break, id_teq, id_eret, teq_eq,
           id_pc, status, epc_in, ext_int,
    output exception, eret, cause, exc_pc, redirect, redirect_pc, flush, busy
  );
`else
  modport master (
    output stall, id_valid, id_syscall, id_break, id_teq, id_eret, teq_eq,
           id_pc, status, epc_in,
    input  exception, eret, cause, exc_pc, redirect, redirect_pc, flush, busy
  );
  modport slave (
    input  stall, id_valid, id_syscall, id_break, id_teq, id_eret, teq_eq,
           id_pc, status, epc_in,
    output exception, eret, cause, exc_pc, redirect, redirect_pc, flush, busy
  );
`endif
endinterface

// File: rtl/exc_issuer.sv
// rtl/exc_issuer.sv - exception/ERET issue unit between decode and CP0; EXC_INT_EN adds the external interrupt path
module exc_issuer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic          clk_i,
  input logic          rst_ni,
  exc_issuer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, ERET, FLUSH} state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] exc_pc_q, exc_pc_d;

  logic accept;
  logic glb_en;
  logic syscall_ok, break_ok, teq_ok, int_ok;

  assign accept     = bus.id_valid & ~bus.stall;
  assign glb_en     = bus.status[0];
  assign syscall_ok = bus.id_syscall & glb_en & bus.status[1];
  assign break_ok   = bus.id_break & glb_en & bus.status[2];
  assign teq_ok     = bus.id_teq & glb_en & bus.status[3] & bus.teq_eq;

`ifdef EXC_INT_EN
  logic sync1_q, sync2_q, pend_q, pend_d;
  logic int_clr;

  // Cause 0 is only ever issued for an interrupt, so it marks the taking cycle.
  assign int_clr = (state_q == ISSUE) && (cause_q == 5'd0);
  assign pend_d  = sync2_q | (pend_q & ~int_clr);
  assign int_ok  = pend_q & glb_en & bus.status[4];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync1_q <= bus.ext_int;
      sync2_q <= sync1_q;
      pend_q  <= pend_d;
    end
  end

  logic unused_status;
  assign unused_status = ^bus.status[31:5];
`else
  assign int_ok = 1'b0;

  logic unused_status;
  assign unused_status = ^bus.status[31:4];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      cause_q  <= 5'd0;
      exc_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      exc_pc_q <= exc_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    exc_pc_d = exc_pc_q;
    unique case (state_q)
      IDLE: begin
        // Only the highest-priority source is taken; decode re-presents the rest.
        if (accept) begin
          if (bus.id_eret) begin
            state_d = ERET;
          end else if (int_ok) begin
            state_d  = ISSUE;
            cause_d  = 5'd0;
            exc_pc_d = bus.id_pc;
          end else if (syscall_ok) begin
            state_d  = ISSUE;
            cause_d  = 5'd8;
            exc_pc_d = bus.id_pc;
          end else if (break_ok) begin
            state_d  = ISSUE;
            cause_d  = 5'd9;
            exc_pc_d = bus.id_pc;
          end else if (teq_ok) begin
            state_d  = ISSUE;
            cause_d  = 5'd13;
            exc_pc_d = bus.id_pc;
          end
        end
      end
      ISSUE, ERET: begin
        state_d = FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset drops them at once.
  assign bus.exception   = (state_q == ISSUE);
  assign bus.eret        = (state_q == ERET);
  assign bus.redirect    = (state_q == ISSUE) || (state_q == ERET);
  assign bus.redirect_pc = (state_q == ISSUE) ? EXC_VECTOR :
                           (state_q == ERET)  ? bus.epc_in : 32'd0;
  assign bus.flush       = (state_q != IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.cause       = cause_q;
  assign bus.exc_pc      = exc_pc_q;

endmodule
